// File: rtl/mii_mac_frame_checker.sv
// Receive-side MII frame checker: delineates Start..Terminate frames on a 64-bit/8-lane word
// stream, forwards frame bytes with a keep mask, checks CRC-32 and length, and captures headers.
module mii_mac_frame_checker #(
    parameter int PAYLOAD_MAX_SIZE = 1500,
    parameter int PAYLOAD_MIN_SIZE = 46
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic [63:0] i_mii_rx_d,
    input  logic [7:0]  i_mii_rx_c,
    output logic [63:0] o_rx_data,
    output logic [7:0]  o_rx_keep,
    output logic        o_rx_last,
    output logic        o_frame_done,
    output logic        o_crc_err,
    output logic        o_len_err,
    output logic        o_abort,
    output logic [47:0] o_dest_address,
    output logic [47:0] o_src_address,
    output logic [15:0] o_eth_type,
    output logic [15:0] o_payload_length,
    output logic [15:0] o_good_cnt,
    output logic [15:0] o_bad_cnt
);

    localparam logic [63:0] START_WORD  = 64'hD555_5555_5555_55FB;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [15:0] MIN_PAY     = 16'(PAYLOAD_MIN_SIZE);
    localparam logic [15:0] MAX_PAY     = 16'(PAYLOAD_MAX_SIZE);

    typedef enum logic {IDLE, DATA} state_t;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        return c;
    endfunction

    function automatic logic [63:0] lane_mask(input logic [7:0] keep);
        logic [63:0] m;
        for (int i = 0; i < 8; i++)
            m[8*i +: 8] = {8{keep[i]}};
        return m;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {13'h0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Terminate at lane k: control lanes k..7, FD in lane k, idles (07) above it.
    function automatic logic term_at(input logic [63:0] d, input logic [7:0] c, input int k);
        logic ok;
        ok = (c == 8'(8'hFF << k)) && (d[8*k +: 8] == 8'hFD);
        for (int j = 0; j < 8; j++)
            if (j > k && d[8*j +: 8] != 8'h07)
                ok = 1'b0;
        return ok;
    endfunction

    state_t      state_q, state_d;
    logic [63:0] hold_data_p0, hold_data_d;
    logic [7:0]  hold_keep_p0, hold_keep_d;
    logic        tail_pend_p0, tail_pend_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  hdr_q [14];
    logic [7:0]  hdr_d [14];

    logic        term_hit;
    logic [2:0]  term_lane;
    logic [7:0]  tail_keep;
    logic [63:0] beat_data;
    logic [7:0]  beat_keep;
    logic        beat_last;
    logic        done;
    logic        abort_hit;
    logic [7:0]  acc_keep;

    logic        short_frame;
    logic [15:0] pay_len;
    logic        len_bad;
    logic        crc_bad;

    always_comb begin
        term_hit  = 1'b0;
        term_lane = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (term_at(i_mii_rx_d, i_mii_rx_c, k)) begin
                term_hit  = 1'b1;
                term_lane = 3'(k);
            end
        end
    end

    assign tail_keep = ~(8'hFF << term_lane);

    // Status evaluated against the already-accumulated count/CRC of the frame being closed.
    assign short_frame = cnt_q < 16'd18;
    assign pay_len     = cnt_q - 16'd18;
    assign len_bad     = short_frame || (pay_len < MIN_PAY) || (pay_len > MAX_PAY);
    assign crc_bad     = short_frame || (crc_q != CRC_RESIDUE);

    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_p0;
        hold_keep_d = hold_keep_p0;
        tail_pend_d = tail_pend_p0;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        hdr_d       = hdr_q;
        beat_data   = '0;
        beat_keep   = '0;
        beat_last   = 1'b0;
        done        = 1'b0;
        abort_hit   = 1'b0;
        acc_keep    = '0;

        case (state_q)
            IDLE: begin
                if (tail_pend_p0) begin
                    beat_data   = hold_data_p0;
                    beat_keep   = hold_keep_p0;
                    beat_last   = 1'b1;
                    done        = 1'b1;
                    tail_pend_d = 1'b0;
                    hold_keep_d = '0;
                end
                if (i_mii_rx_c == 8'h01 && i_mii_rx_d == START_WORD) begin
                    state_d = DATA;
                    crc_d   = '1;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                beat_data = hold_data_p0;
                beat_keep = hold_keep_p0;
                if (i_mii_rx_c == 8'h00) begin
                    hold_data_d = i_mii_rx_d;
                    hold_keep_d = 8'hFF;
                    acc_keep    = 8'hFF;
                end else if (term_hit && term_lane == 3'd0) begin
                    beat_last   = 1'b1;
                    done        = 1'b1;
                    hold_keep_d = '0;
                    state_d     = IDLE;
                end else if (term_hit) begin
                    hold_data_d = i_mii_rx_d & lane_mask(tail_keep);
                    hold_keep_d = tail_keep;
                    acc_keep    = tail_keep;
                    tail_pend_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    beat_last   = 1'b1;
                    done        = 1'b1;
                    abort_hit   = 1'b1;
                    hold_keep_d = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        for (int i = 0; i < 8; i++) begin
            if (acc_keep[i]) begin
                crc_d = crc_byte(crc_d, i_mii_rx_d[8*i +: 8]);
                if (int'(cnt_q) + i < 14)
                    hdr_d[4'(int'(cnt_q) + i)] = i_mii_rx_d[8*i +: 8];
            end
        end
        if (acc_keep != 8'h00)
            cnt_d = sat_add(cnt_q, 4'($countones(acc_keep)));
    end

    // Stage p0: held word and header shadow (data only, no reset)
    always_ff @(posedge clk) begin
        hold_data_p0 <= hold_data_d;
        hdr_q        <= hdr_d;
    end

    // Stage p1: control state and registered outputs
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q          <= IDLE;
            hold_keep_p0     <= '0;
            tail_pend_p0     <= 1'b0;
            crc_q            <= '1;
            cnt_q            <= '0;
            o_rx_data        <= '0;
            o_rx_keep        <= '0;
            o_rx_last        <= 1'b0;
            o_frame_done     <= 1'b0;
            o_crc_err        <= 1'b0;
            o_len_err        <= 1'b0;
            o_abort          <= 1'b0;
            o_dest_address   <= '0;
            o_src_address    <= '0;
            o_eth_type       <= '0;
            o_payload_length <= '0;
            o_good_cnt       <= '0;
            o_bad_cnt        <= '0;
        end else begin
            state_q      <= state_d;
            hold_keep_p0 <= hold_keep_d;
            tail_pend_p0 <= tail_pend_d;
            crc_q        <= crc_d;
            cnt_q        <= cnt_d;
            o_rx_data    <= beat_data & lane_mask(beat_keep);
            o_rx_keep    <= beat_keep;
            o_rx_last    <= beat_last;
            o_frame_done <= done;
            o_crc_err    <= done && !abort_hit && crc_bad;
            o_len_err    <= done && !abort_hit && len_bad;
            o_abort      <= abort_hit;
            if (done) begin
                o_dest_address   <= {hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3], hdr_q[4], hdr_q[5]};
                o_src_address    <= {hdr_q[6], hdr_q[7], hdr_q[8], hdr_q[9], hdr_q[10], hdr_q[11]};
                o_eth_type       <= {hdr_q[12], hdr_q[13]};
                o_payload_length <= pay_len;
                if (abort_hit || crc_bad || len_bad)
                    o_bad_cnt <= o_bad_cnt + 16'd1;
                else
                    o_good_cnt <= o_good_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mii_mac_frame_checker.sv
// Scoreboard bench for mii_mac_frame_checker: directed frames push expected beats into a queue,
// an independent negedge monitor pops and compares whenever the DUT presents a beat or frame_done.
module tb_mii_mac_frame_checker;

    localparam logic [63:0] START_W  = 64'hD555_5555_5555_55FB;
    localparam logic [63:0] BADST_W  = 64'h5555_5555_5555_55FB;
    localparam logic [63:0] IDLE_W   = 64'h0707_0707_0707_0707;
    localparam logic [47:0] DST      = 48'h0A0B_0C0D_0E0F;
    localparam logic [47:0] SRC      = 48'h1122_3344_5566;
    localparam logic [15:0] ETYPE    = 16'h0800;

    logic        clk;
    logic        i_rst;
    logic [63:0] mii_d;
    logic [7:0]  mii_c;
    logic [63:0] o_rx_data;
    logic [7:0]  o_rx_keep;
    logic        o_rx_last, o_frame_done, o_crc_err, o_len_err, o_abort;
    logic [47:0] o_dest_address, o_src_address;
    logic [15:0] o_eth_type, o_payload_length, o_good_cnt, o_bad_cnt;

    mii_mac_frame_checker dut (
        .clk(clk), .i_rst(i_rst), .i_mii_rx_d(mii_d), .i_mii_rx_c(mii_c),
        .o_rx_data(o_rx_data), .o_rx_keep(o_rx_keep), .o_rx_last(o_rx_last),
        .o_frame_done(o_frame_done), .o_crc_err(o_crc_err), .o_len_err(o_len_err),
        .o_abort(o_abort), .o_dest_address(o_dest_address), .o_src_address(o_src_address),
        .o_eth_type(o_eth_type), .o_payload_length(o_payload_length),
        .o_good_cnt(o_good_cnt), .o_bad_cnt(o_bad_cnt)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        abt;
        logic        cerr;
        logic        lerr;
        logic        hchk;
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] et;
        logic [15:0] plen;
        logic [15:0] good;
        logic [15:0] bad;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        me;
    logic [7:0]  fb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_good = 0;
    logic [15:0] exp_bad  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] mask_of(input logic [7:0] k);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    always @(negedge clk) begin
        if (o_rx_keep != 8'h00 || o_rx_last || o_frame_done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_beat: got keep=%0h last=%0b done=%0b expected no beat",
                         o_rx_keep, o_rx_last, o_frame_done);
            end else begin
                me = exp_q.pop_front();
                chk("rx_keep", 64'(o_rx_keep), 64'(me.keep));
                chk("rx_data", o_rx_data & mask_of(me.keep), me.data & mask_of(me.keep));
                chk("rx_last", 64'(o_rx_last), 64'(me.last));
                chk("frame_done", 64'(o_frame_done), 64'(me.last));
                if (me.last) begin
                    chk("abort", 64'(o_abort), 64'(me.abt));
                    chk("crc_err", 64'(o_crc_err), 64'(me.cerr));
                    chk("len_err", 64'(o_len_err), 64'(me.lerr));
                    chk("good_cnt", 64'(o_good_cnt), 64'(me.good));
                    chk("bad_cnt", 64'(o_bad_cnt), 64'(me.bad));
                    if (me.hchk) begin
                        chk("dest_address", 64'(o_dest_address), 64'(me.dst));
                        chk("src_address", 64'(o_src_address), 64'(me.src));
                        chk("eth_type", 64'(o_eth_type), 64'(me.et));
                        chk("payload_length", 64'(o_payload_length), 64'(me.plen));
                    end
                end
            end
        end
    end

    task automatic put_word(input logic [63:0] d, input logic [7:0] c);
        @(negedge clk);
        mii_d = d;
        mii_c = c;
    endtask

    task automatic push_exp(input logic [63:0] d, input logic [7:0] k, input bit last,
                            input bit abt, input bit cerr, input bit lerr, input bit hchk,
                            input logic [15:0] plen);
        exp_t e;
        e.data = d; e.keep = k; e.last = last; e.abt = abt; e.cerr = cerr; e.lerr = lerr;
        e.hchk = hchk; e.dst = DST; e.src = SRC; e.et = ETYPE; e.plen = plen;
        e.good = exp_good; e.bad = exp_bad;
        exp_q.push_back(e);
    endtask

    function automatic logic [63:0] word_at(input int base, input int cnt);
        logic [63:0] w;
        w = '0;
        for (int j = 0; j < cnt; j++) w[8*j +: 8] = fb[base + j];
        return w;
    endfunction

    // Frame = DST, SRC, ETYPE, payload, FCS (complement of CRC, LSB first).
    task automatic build_frame(input int plen, input bit ramp);
        logic [31:0] crc;
        logic [7:0]  b;
        fb.delete();
        for (int i = 5; i >= 0; i--) fb.push_back(DST[8*i +: 8]);
        for (int i = 5; i >= 0; i--) fb.push_back(SRC[8*i +: 8]);
        fb.push_back(ETYPE[15:8]);
        fb.push_back(ETYPE[7:0]);
        for (int i = 0; i < plen; i++) fb.push_back(ramp ? 8'(i) : 8'h55);
        crc = 32'hFFFF_FFFF;
        foreach (fb[i]) begin
            b = fb[i];
            for (int k = 0; k < 8; k++) begin
                if (crc[0] ^ b[k]) crc = (crc >> 1) ^ 32'hEDB8_8320;
                else crc = crc >> 1;
            end
        end
        crc = ~crc;
        for (int i = 0; i < 4; i++) fb.push_back(crc[8*i +: 8]);
    endtask

    task automatic send_frame(input bit good_start, input bit crc_bad);
        int n, nf, rem, plen;
        bit lerr;
        logic [63:0] tw;
        n = fb.size(); nf = n / 8; rem = n % 8; plen = n - 18;
        lerr = (n < 18) || (plen < 46) || (plen > 1500);
        if (good_start) begin
            if (crc_bad || lerr) exp_bad++;
            else exp_good++;
            for (int i = 0; i < nf; i++) begin
                if (rem == 0 && i == nf - 1)
                    push_exp(word_at(8*i, 8), 8'hFF, 1'b1, 1'b0, crc_bad, lerr, 1'b1, 16'(plen));
                else
                    push_exp(word_at(8*i, 8), 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'(plen));
            end
            if (rem != 0)
                push_exp(word_at(8*nf, rem), 8'(~(8'hFF << rem)), 1'b1, 1'b0, crc_bad, lerr,
                         1'b1, 16'(plen));
        end
        put_word(good_start ? START_W : BADST_W, 8'h01);
        for (int i = 0; i < nf; i++) put_word(word_at(8*i, 8), 8'h00);
        tw = word_at(8*nf, rem);
        tw[8*rem +: 8] = 8'hFD;
        for (int j = rem + 1; j < 8; j++) tw[8*j +: 8] = 8'h07;
        put_word(tw, 8'(8'hFF << rem));
        put_word(IDLE_W, 8'hFF);
        put_word(IDLE_W, 8'hFF);
    endtask

    initial begin
        i_rst = 1'b1;
        mii_d = IDLE_W;
        mii_c = 8'hFF;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        chk("reset_keep", 64'(o_rx_keep), 64'd0);
        chk("reset_data", o_rx_data, 64'd0);
        chk("reset_last", 64'(o_rx_last), 64'd0);
        chk("reset_done", 64'(o_frame_done), 64'd0);
        chk("reset_dest", 64'(o_dest_address), 64'd0);
        chk("reset_good", 64'(o_good_cnt), 64'd0);
        chk("reset_bad", 64'(o_bad_cnt), 64'd0);

        // 64B good frame, terminate in lane 0
        build_frame(46, 1'b0);
        send_frame(1'b1, 1'b0);
        // 65B good frame, terminate in lane 1
        build_frame(47, 1'b0);
        send_frame(1'b1, 1'b0);
        // 64B frame with a payload byte flipped after FCS
        build_frame(46, 1'b0);
        fb[20] = fb[20] ^ 8'h01;
        send_frame(1'b1, 1'b1);
        // undersized (payload 22) and oversized (payload 1501) frames
        build_frame(22, 1'b0);
        send_frame(1'b1, 1'b0);
        build_frame(1501, 1'b1);
        send_frame(1'b1, 1'b0);

        // abort: FE in lane 4 after three data words
        build_frame(46, 1'b0);
        exp_bad++;
        push_exp(word_at(0, 8), 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        push_exp(word_at(8, 8), 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        push_exp(word_at(16, 8), 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        put_word(START_W, 8'h01);
        for (int i = 0; i < 3; i++) put_word(word_at(8*i, 8), 8'h00);
        put_word(64'h2222_22FE_1111_1111, 8'h10);
        put_word(IDLE_W, 8'hFF);
        build_frame(46, 1'b0);
        send_frame(1'b1, 1'b0);

        // malformed start word (lane 7 = 55): whole frame ignored
        build_frame(46, 1'b0);
        send_frame(1'b0, 1'b0);

        // reset mid-frame: only the first beat escapes, no done, counters cleared
        build_frame(46, 1'b0);
        push_exp(word_at(0, 8), 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        put_word(START_W, 8'h01);
        put_word(word_at(0, 8), 8'h00);
        put_word(word_at(8, 8), 8'h00);
        @(negedge clk);
        i_rst = 1'b1;
        mii_d = IDLE_W;
        mii_c = 8'hFF;
        @(negedge clk);
        i_rst = 1'b0;
        exp_good = 0;
        exp_bad  = 0;
        @(negedge clk);
        chk("rst_mid_good", 64'(o_good_cnt), 64'(exp_good));
        chk("rst_mid_bad", 64'(o_bad_cnt), 64'(exp_bad));
        chk("rst_mid_dest", 64'(o_dest_address), 64'd0);
        chk("rst_mid_done", 64'(o_frame_done), 64'd0);
        build_frame(46, 1'b0);
        send_frame(1'b1, 1'b0);

        repeat (5) @(negedge clk);
        chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
